// File: rtl/pll_reset_sequencer.sv
// Bring-up sequencer for the HDMI clocking chain: rPLL reset, lock qualification,
// divider release, settle, then game reset release; restarts on lock loss or request.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 64,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 32,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       div_rst_n_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [2:0] retry_cnt_o,
    output logic [7:0] lock_lost_cnt_o
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
    localparam int MAX_CD  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_DIV_EN    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stab_q, stab_d;
    logic [2:0]    retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic          sync1_q, lock_s_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_PLL_RST;
            cnt_q    <= '0;
            stab_q   <= '0;
            retry_q  <= '0;
            lost_q   <= '0;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stab_q   <= stab_d;
            retry_q  <= retry_d;
            lost_q   <= lost_d;
            sync1_q  <= pll_lock_i;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        stab_d  = '0;
        retry_d = retry_q;
        lost_d  = lost_q;

        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                stab_d = lock_s_q ? (stab_q + CW'(1)) : '0;
                // A qualified lock beats a timeout landing on the same cycle
                if (lock_s_q && (stab_q == STABLE_LAST)) begin
                    state_d = ST_DIV_EN;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_PLL_RST;
                    end
                end
            end
            ST_DIV_EN: begin
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end
            end
            ST_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        // Restart overrides everything, including a coincident lock-loss count
        if (restart_i && (state_q != ST_PLL_RST)) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
            lost_d  = lost_q;
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end
    end

    always_comb begin
        pll_rst_o   = 1'b0;
        div_rst_n_o = 1'b0;
        sys_rst_o   = 1'b1;
        ready_o     = 1'b0;
        fail_o      = 1'b0;
        unique case (state_q)
            ST_PLL_RST:   pll_rst_o = 1'b1;
            ST_WAIT_LOCK: ;
            ST_DIV_EN:    div_rst_n_o = 1'b1;
            ST_RUN: begin
                div_rst_n_o = 1'b1;
                sys_rst_o   = 1'b0;
                ready_o     = 1'b1;
            end
            ST_FAIL: begin
                pll_rst_o = 1'b1;
                fail_o    = 1'b1;
            end
            default:      pll_rst_o = 1'b1;
        endcase
    end

    assign state_o         = state_q;
    assign retry_cnt_o     = retry_q;
    assign lock_lost_cnt_o = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboarded bench: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, lock, restart;
    logic       pll_rst, div_rst_n, sys_rst, ready, fail;
    logic [2:0] state, retry;
    logic [7:0] lost;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE   (8),
        .LOCK_TIMEOUT  (32),
        .SETTLE_CYCLES (4),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pll_lock_i     (lock),
        .restart_i      (restart),
        .pll_rst_o      (pll_rst),
        .div_rst_n_o    (div_rst_n),
        .sys_rst_o      (sys_rst),
        .ready_o        (ready),
        .fail_o         (fail),
        .state_o        (state),
        .retry_cnt_o    (retry),
        .lock_lost_cnt_o(lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [2:0] retry;
        logic [7:0] lost;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Expected output vector: {state, pll_rst, div_rst_n, sys_rst, ready, fail, retry, lost}
    function automatic logic [21:0] pack_exp(logic [2:0] st, logic [2:0] r, logic [7:0] l);
        logic [4:0] o;
        case (st)
            3'd0:    o = 5'b10100;
            3'd1:    o = 5'b00100;
            3'd2:    o = 5'b01100;
            3'd3:    o = 5'b01010;
            3'd4:    o = 5'b10101;
            default: o = 5'b00000;
        endcase
        return {st, o, r, l};
    endfunction

    task automatic push(int c, logic [2:0] st, logic [2:0] r, logic [7:0] l, string nm);
        exp_t e;
        e.cyc = c; e.st = st; e.retry = r; e.lost = l; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Nominal bring-up from PLL_RST entered at cycle p with lock already present
    task automatic bringup(int p, logic [7:0] l, string nm);
        push(p + 3,  3'd0, 3'd0, l, {nm, "_pllrst_end"});
        push(p + 4,  3'd1, 3'd0, l, {nm, "_wait_start"});
        push(p + 11, 3'd1, 3'd0, l, {nm, "_wait_end"});
        push(p + 12, 3'd2, 3'd0, l, {nm, "_div_start"});
        push(p + 15, 3'd2, 3'd0, l, {nm, "_div_end"});
        push(p + 16, 3'd3, 3'd0, l, {nm, "_run"});
    endtask

    // One-cycle lock dip while in RUN; returns in RUN after the rebuild
    task automatic dip(logic [7:0] lb, string nm);
        int c1;
        c1 = cyc;
        push(c1 + 2, 3'd3, 3'd0, lb, {nm, "_still_run"});
        push(c1 + 3, 3'd0, 3'd0, lb + 8'd1, {nm, "_lost"});
        bringup(c1 + 3, lb + 8'd1, nm);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(18);
    endtask

    exp_t        m_e;
    logic [21:0] m_act, m_exp;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e   = sb.pop_front();
            m_act = {state, pll_rst, div_rst_n, sys_rst, ready, fail, retry, lost};
            m_exp = pack_exp(m_e.st, m_e.retry, m_e.lost);
            total++;
            if (m_e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", m_e.name, m_e.cyc, cyc);
            end else if (m_act !== m_exp) begin
                bad++;
                $display("FAIL %s @%0d: got st=%0d pr=%b drn=%b sr=%b rdy=%b fl=%b rt=%0d ll=%0d want %h got %h",
                         m_e.name, cyc, state, pll_rst, div_rst_n, sys_rst, ready, fail, retry, lost, m_exp, m_act);
            end else begin
                $display("ok %s @%0d st=%0d rt=%0d ll=%0d", m_e.name, cyc, state, retry, lost);
            end
        end
    end

    initial begin
        int p;
        rst_n   = 1'b0;
        lock    = 1'b1;
        restart = 1'b0;
        step(3);

        // 1: lock present from reset
        push(cyc, 3'd0, 3'd0, 8'd0, "reset");
        p = cyc;
        rst_n = 1'b1;
        bringup(p, 8'd0, "t1");
        step(16);

        // 3: single-cycle lock loss in RUN
        step(2);
        dip(8'd0, "t3");

        // 4: glitch during WAIT_LOCK restarts the stability count
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        p = cyc;
        push(p,      3'd0, 3'd0, 8'd1, "t4_restart");
        push(p + 4,  3'd1, 3'd0, 8'd1, "t4_wait_start");
        push(p + 12, 3'd1, 3'd0, 8'd1, "t4_still_wait");
        push(p + 17, 3'd1, 3'd0, 8'd1, "t4_wait_end");
        push(p + 18, 3'd2, 3'd0, 8'd1, "t4_div_start");
        push(p + 21, 3'd2, 3'd0, 8'd1, "t4_div_end");
        push(p + 22, 3'd3, 3'd0, 8'd1, "t4_run");
        step(7);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(14);

        // 2: lock never arrives; restart coincides with lock loss in RUN
        step(2);
        push(cyc + 2, 3'd3, 3'd0, 8'd1, "t2_run_before");
        lock = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        p = cyc;
        push(p,       3'd0, 3'd0, 8'd1, "t2_restart_wins");
        push(p + 35,  3'd1, 3'd0, 8'd1, "t2_att1_wait_end");
        push(p + 36,  3'd0, 3'd1, 8'd1, "t2_att2");
        push(p + 71,  3'd1, 3'd1, 8'd1, "t2_att2_wait_end");
        push(p + 72,  3'd0, 3'd2, 8'd1, "t2_att3");
        push(p + 107, 3'd1, 3'd2, 8'd1, "t2_att3_wait_end");
        push(p + 108, 3'd4, 3'd2, 8'd1, "t2_fail");
        push(p + 150, 3'd4, 3'd2, 8'd1, "t2_fail_held");
        step(150);

        // 5: restart from FAIL with lock held
        restart = 1'b1;
        lock    = 1'b1;
        step(1);
        restart = 1'b0;
        p = cyc;
        push(p, 3'd0, 3'd0, 8'd1, "t5_restart");
        bringup(p, 8'd1, "t5");
        step(16);

        // 6: bump loss count to 3, then reset during DIV_EN
        step(2);
        dip(8'd1, "t6a");
        step(2);
        dip(8'd2, "t6b");
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        p = cyc;
        push(p,      3'd0, 3'd0, 8'd3, "t6_restart");
        push(p + 12, 3'd2, 3'd0, 8'd3, "t6_div");
        step(13);
        push(cyc, 3'd2, 3'd0, 8'd3, "t6_div_pre_reset");
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        p = cyc;
        push(p, 3'd0, 3'd0, 8'd0, "t6_after_reset");
        bringup(p, 8'd0, "t6_rebuild");
        step(20);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Free-running sequencer clocked by the 27 MHz board oscillator. It brings up the HDMI clocking chain in order: rPLL reset, wait for a stable lock, release the CLKDIV2/CLKDIV resets, settle, then release the game reset. It restarts the chain on lock loss or on request, retries a bounded number of times, and reports status for LEDs. It is instantiated in the board top between the PLL/divider primitives and game_top.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst_o is held high per attempt (>=1)
LOCK_STABLE, 64, consecutive synchronized-lock cycles required (>=1)
LOCK_TIMEOUT, 65536, maximum WAIT_LOCK cycles per attempt (> LOCK_STABLE)
SETTLE_CYCLES, 32, cycles between divider release and system reset release (>=1)
MAX_RETRIES, 7, failed attempts allowed before FAIL (>=0)

Ports:
clk_i  input  1  27 MHz reference clock, free-running, never from the PLL
rst_n_i  input  1  reset, synchronous, active-low
pll_lock_i  input  1  rPLL LOCK, asynchronous to clk_i
restart_i  input  1  single-cycle restart request, clk_i domain
pll_rst_o  output  1  to rPLL RESET, active-high
div_rst_n_o  output  1  to CLKDIV2/CLKDIV RESETN, active-low
sys_rst_o  output  1  game reset level, active-high; the consumer synchronizes it into pixel_clk
ready_o  output  1  high only in RUN
fail_o  output  1  high only in FAIL
state_o  output  3  PLL_RST=0, WAIT_LOCK=1, DIV_EN=2, RUN=3, FAIL=4
retry_cnt_o  output  3  failed attempts in the current bring-up
lock_lost_cnt_o  output  8  lock-loss events after lock was achieved, saturating

Behaviour:
- Single clock domain. All state updates on posedge clk_i. rst_n_i=0 at an edge is the only reset.
- Reset values: state=PLL_RST, all counters=0, lock sync flops=0, retry_cnt_o=0, lock_lost_cnt_o=0.
- pll_lock_i passes through a 2-flop synchronizer; lock_s is the second flop. There is no other use of the raw input.
- Outputs are decoded from the state register (Moore) with no extra register:
  - PLL_RST: pll_rst=1, div_rst_n=0, sys_rst=1
  - WAIT_LOCK: 0, 0, 1
  - DIV_EN: 0, 1, 1
  - RUN: 0, 1, 0, ready=1
  - FAIL: 1, 0, 1, fail=1
- A single cycle counter cnt is cleared on every state entry. A separate stable counter stab is used in WAIT_LOCK. Counter width is $clog2 of the largest parameter plus 1.
- PLL_RST: cnt increments. At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. Dwell is exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK: cnt increments every cycle. stab increments when lock_s=1 and clears when lock_s=0.
  - lock_s=1 and stab==LOCK_STABLE-1: go to DIV_EN. This has priority over the timeout in the same cycle.
  - Else cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES, go to FAIL; otherwise retry_cnt+1 and go to PLL_RST.
- DIV_EN: cnt increments.
  - lock_s=0: go to PLL_RST, lock_lost_cnt+1 (saturating at 255). retry_cnt is unchanged.
  - Else cnt==SETTLE_CYCLES-1: go to RUN and clear retry_cnt.
- RUN: lock_s=0 goes to PLL_RST with lock_lost_cnt+1 (saturating). The next cycle therefore shows pll_rst=1, div_rst_n=0, sys_rst=1.
- FAIL: terminal. Left only by rst_n_i or restart_i.
- restart_i=1 in any state except PLL_RST: go to PLL_RST, clear retry_cnt. It takes priority over every other transition. In PLL_RST it is ignored, and the counter is not restarted.
- restart_i and lock loss in the same RUN cycle: restart wins and lock_lost_cnt is not incremented.
- Reset mid-operation returns to PLL_RST immediately and clears all counters, including lock_lost_cnt.

Test Plan:
Parameters for all scenarios unless noted: PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, SETTLE_CYCLES=4, MAX_RETRIES=2.
1. pll_lock_i=1 from reset, release rst_n_i -> pll_rst_o high exactly 4 cycles, WAIT_LOCK 8 cycles, DIV_EN 4 cycles; ready_o=1 and sys_rst_o=0 on the 17th cycle after release; retry_cnt_o=0.
2. pll_lock_i=0 permanently -> 3 attempts of 4+32 cycles each; retry_cnt_o goes 0→1→2; FAIL at cycle 108; fail_o=1, pll_rst_o=1, sys_rst_o=1 held indefinitely.
3. In RUN, drop pll_lock_i for 1 cycle -> state_o=0 exactly 3 cycles later (2 sync plus 1 transition); lock_lost_cnt_o=1; sequence completes again once lock returns.
4. In WAIT_LOCK, toggle lock_i 1 for 5 cycles, 0 for 1 cycle, then 1 -> stab restarts; DIV_EN is entered only after 8 consecutive synced-high cycles.
5. In FAIL, pulse restart_i -> PLL_RST next cycle, fail_o=0, retry_cnt_o=0; with lock then held, RUN is reached.
6. Assert rst_n_i=0 for 1 cycle during DIV_EN with lock_lost_cnt_o=3 -> PLL_RST next cycle, all counters 0, div_rst_n_o=0.
